// File: rtl/router_egress_scheduler_if.sv
// Egress scheduler bus bundle: FIFO read side plus the downstream valid/ready byte link.
interface router_egress_scheduler_if #(
  parameter int unsigned DW = 8
);
  logic [2:0]    fifo_empty;
  logic [DW-1:0] fifo_dout0;
  logic [DW-1:0] fifo_dout1;
  logic [DW-1:0] fifo_dout2;
  logic [2:0]    fifo_rd_en;
  logic [2:0]    fifo_sft_rst;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_sop;
  logic          m_eop;
  logic [1:0]    m_src;
  logic          busy;
  logic          abort;

  // Scheduler view.
  modport master (
    input  fifo_empty, fifo_dout0, fifo_dout1, fifo_dout2, m_ready,
    output fifo_rd_en, fifo_sft_rst, m_data, m_valid, m_sop, m_eop, m_src, busy, abort
  );

  // FIFO / downstream environment view.
  modport slave (
    output fifo_empty, fifo_dout0, fifo_dout1, fifo_dout2, m_ready,
    input  fifo_rd_en, fifo_sft_rst, m_data, m_valid, m_sop, m_eop, m_src, busy, abort
  );
endinterface

// File: rtl/router_egress_scheduler.sv
// Packet-granular round-robin drain of three FWFT router FIFOs onto one byte link,
// with an underrun timeout that aborts a stalled packet and soft-resets its FIFO.
module router_egress_scheduler #(
  parameter int unsigned DW      = 8,
  parameter int unsigned TIMEOUT = 30
) (
  input  logic                      clk,
  input  logic                      rstn,
  router_egress_scheduler_if.master bus
);

  localparam int unsigned NF = 3;
  localparam int unsigned SW = 2;
  localparam int unsigned LW = 6;
  localparam int unsigned CW = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_BODY  = 3'd2,
    S_PAR   = 3'd3,
    S_ABORT = 3'd4
  } state_t;

  state_t          state;
  logic [SW-1:0]   gnt;
  logic [SW-1:0]   ptr;
  logic [LW-1:0]   rem;
  logic [CW-1:0]   stall_cnt;

  logic            gnt_empty;
  logic [DW-1:0]   gnt_dout;
  logic            active;
  logic            valid;
  logic            xfer;
  logic [LW-1:0]   hdr_len;
  logic [SW-1:0]   cand1;
  logic [SW-1:0]   cand2;
  logic [SW-1:0]   pick;

  // Modulo-3 increment of a FIFO index.
  function automatic logic [SW-1:0] inc3(input logic [SW-1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  function automatic logic has_data(input logic [NF-1:0] empty, input logic [SW-1:0] i);
    case (i)
      2'd0:    has_data = !empty[0];
      2'd1:    has_data = !empty[1];
      2'd2:    has_data = !empty[2];
      default: has_data = 1'b0;
    endcase
  endfunction

  function automatic logic [NF-1:0] onehot(input logic [SW-1:0] i);
    case (i)
      2'd0:    onehot = 3'b001;
      2'd1:    onehot = 3'b010;
      2'd2:    onehot = 3'b100;
      default: onehot = 3'b000;
    endcase
  endfunction

  // Head of the granted FIFO.
  always_comb begin
    gnt_empty = 1'b1;
    gnt_dout  = '0;
    case (gnt)
      2'd0: begin gnt_empty = bus.fifo_empty[0]; gnt_dout = bus.fifo_dout0; end
      2'd1: begin gnt_empty = bus.fifo_empty[1]; gnt_dout = bus.fifo_dout1; end
      2'd2: begin gnt_empty = bus.fifo_empty[2]; gnt_dout = bus.fifo_dout2; end
      default: ;
    endcase
  end

  // Round-robin search starting at ptr.
  assign cand1 = inc3(ptr);
  assign cand2 = inc3(cand1);
  assign pick  = has_data(bus.fifo_empty, ptr)   ? ptr   :
                 has_data(bus.fifo_empty, cand1) ? cand1 : cand2;

  assign active  = (state == S_HDR) || (state == S_BODY) || (state == S_PAR);
  assign valid   = active && !gnt_empty;
  assign xfer    = valid && bus.m_ready;
  assign hdr_len = gnt_dout[7:2];

  assign bus.m_valid      = valid;
  assign bus.m_data       = valid ? gnt_dout : '0;
  assign bus.fifo_rd_en   = xfer ? onehot(gnt) : 3'b000;
  assign bus.m_sop        = valid && (state == S_HDR);
  assign bus.m_eop        = valid && (state == S_PAR);
  assign bus.busy         = (state != S_IDLE);
  assign bus.m_src        = (state != S_IDLE) ? gnt : 2'd0;
  assign bus.abort        = (state == S_ABORT);
  assign bus.fifo_sft_rst = (state == S_ABORT) ? onehot(gnt) : 3'b000;

  // Packet FSM; stall_cnt only advances while the granted FIFO is empty.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= S_IDLE;
      gnt       <= '0;
      ptr       <= '0;
      rem       <= '0;
      stall_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          stall_cnt <= '0;
          if (bus.fifo_empty != 3'b111) begin
            gnt   <= pick;
            state <= S_HDR;
          end
        end
        S_HDR, S_BODY, S_PAR: begin
          if (xfer) begin
            stall_cnt <= '0;
            case (state)
              S_HDR: begin
                rem   <= hdr_len;
                state <= (hdr_len == '0) ? S_PAR : S_BODY;
              end
              S_BODY: begin
                rem <= rem - LW'(1);
                if (rem == LW'(1)) state <= S_PAR;
              end
              default: begin
                state <= S_IDLE;
                ptr   <= inc3(gnt);
              end
            endcase
          end else if (gnt_empty) begin
            if (stall_cnt == CW'(TIMEOUT - 1)) begin
              state     <= S_ABORT;
              stall_cnt <= '0;
            end else begin
              stall_cnt <= stall_cnt + CW'(1);
            end
          end
        end
        S_ABORT: begin
          state     <= S_IDLE;
          ptr       <= inc3(gnt);
          stall_cnt <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Structural invariants of the grant datapath.
  a_rd_onehot:  assert property (@(posedge clk) disable iff (!rstn) $onehot0(bus.fifo_rd_en));
  a_gnt_legal:  assert property (@(posedge clk) disable iff (!rstn) gnt != 2'd3);

endmodule

// File: doc/router_egress_scheduler.md
Name: router_egress_scheduler

Overview:
Packet-granular round-robin scheduler that drains the router's three output FIFOs onto one shared downstream byte link with a valid/ready handshake. Once a FIFO is granted, the grant is held until that FIFO's whole packet has been sent: header, payload of header[7:2] bytes, then parity. An underrun timeout aborts a stalled packet and soft-resets the offending FIFO. The block sits between the three router output FIFOs (first-word-fall-through) and the egress link.

Parameters:
DW, 8, data byte width
TIMEOUT, 30, consecutive underrun cycles tolerated mid-packet before abort (2..255)

Ports:
clk  input  1  clock
rstn  input  1  synchronous active-low reset
fifo_empty  input  3  per-FIFO empty flag; bit i = FIFO i
fifo_dout0  input  DW  FIFO0 head data (FWFT, valid when !fifo_empty[0])
fifo_dout1  input  DW  FIFO1 head data
fifo_dout2  input  DW  FIFO2 head data
fifo_rd_en  output  3  pop strobe per FIFO
fifo_sft_rst  output  3  one-cycle soft-reset pulse per FIFO
m_data  output  DW  egress data
m_valid  output  1  egress data valid
m_ready  input  1  downstream accept
m_sop  output  1  beat is the packet header
m_eop  output  1  beat is the parity byte
m_src  output  2  granted FIFO index
busy  output  1  packet in progress
abort  output  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (rstn=0 at clk edge): state=IDLE, gnt=0, ptr=0, rem=0, stall_cnt=0.
  - All outputs 0, including m_data.
  - A reset mid-packet discards the packet silently: no fifo_sft_rst, no abort pulse.
- States and transitions:
  - IDLE -> HDR: when any fifo_empty bit is 0. gnt is registered as the first non-empty FIFO searching ptr, ptr+1, ptr+2 (mod 3).
  - HDR -> BODY: on header transfer; rem is loaded with header[7:2]. If header[7:2]==0, go directly to PAR instead.
  - BODY: each transfer decrements rem. A transfer with rem==1 -> PAR.
  - PAR -> IDLE: on transfer; ptr <= (gnt+1) mod 3.
  - ABORT -> IDLE: one cycle only; ptr <= (gnt+1) mod 3.
- Grant latency: a FIFO that goes non-empty while in IDLE at cycle N gets m_valid at N+1. Minimum IDLE gap between packets is 1 cycle.
- Datapath (combinational from state/gnt):
  - m_valid = (state in HDR/BODY/PAR) & !fifo_empty[gnt].
  - m_data = fifo_dout[gnt] when m_valid, else 0.
  - transfer = m_valid & m_ready.
  - fifo_rd_en[i] = transfer & (i==gnt); at most one bit is set.
  - m_sop = m_valid & (state==HDR); m_eop = m_valid & (state==PAR).
  - m_src = gnt when busy, else 0.
  - busy = (state != IDLE).
- Handshake rules:
  - While m_valid=1 and m_ready=0, m_data/m_sop/m_eop/m_src stay stable and no pop occurs.
  - m_valid never drops without a transfer unless the FIFO is empty (underrun).
- Underrun timeout:
  - In HDR/BODY/PAR, stall_cnt increments on each cycle with fifo_empty[gnt]=1.
  - stall_cnt clears on any transfer and on entering IDLE.
  - Backpressure (m_ready=0 with data present) does not count.
  - If fifo_empty[gnt]=1 while stall_cnt==TIMEOUT-1, next state is ABORT. ABORT is therefore entered after exactly TIMEOUT consecutive empty cycles.
  - In ABORT: fifo_sft_rst[gnt]=1 and abort=1 for that single cycle. m_valid=0 and no pops.
- Other FIFOs going non-empty mid-packet do not preempt the current grant.
- Length field: 6-bit header[7:2], range 0..63. Packet is length+2 beats. The block does not check parity.
- fifo_sft_rst and abort are registered state decodes (glitch-free). All other outputs are combinational from state and inputs, as listed above.

Test Plan:
- Single packet: FIFO1 holds 0x0D,0xA1,0xA2,0xA3,0x5E; m_ready=1 -> m_valid from the cycle after non-empty for 5 consecutive beats in that order. m_sop on beat 0, m_eop on beat 4, m_src=1, fifo_rd_en=3'b010 for 5 cycles, then IDLE and busy=0.
- Round-robin: all three FIFOs preloaded with 1-payload packets (headers 0x04, 0x05, 0x06) -> served in order 0, 1, 2. Then refill FIFO0 and FIFO2 (ptr=0) -> served 0 then 2. No beats are interleaved between packets.
- Backpressure: m_ready=0 for 4 cycles during the BODY of a 3-payload packet -> m_valid=1 with data held stable, fifo_rd_en=0, stall_cnt stays 0, no abort; the packet completes normally.
- Underrun abort: FIFO0 supplies only 0x08 and one payload byte, then stays empty -> after 30 empty cycles, fifo_sft_rst=3'b001 and abort=1 for one cycle, then IDLE. ptr=1: a pending FIFO1 packet is granted next.
- Zero length: header 0x02 followed by parity byte in FIFO2 -> exactly 2 beats; m_sop on beat 0, m_eop on beat 1, m_src=2.
- Reset mid-body: rstn=0 for 1 cycle during BODY -> next cycle state IDLE and all outputs 0, ptr=0, fifo_sft_rst=0, abort=0.
